// File: rtl/vec_packer.sv
// Serial-to-parallel packer: collects up to DATA_LENGTH elements into one packed
// vector for the min/max reduction tree, padding short rows with a neutral value.
module vec_packer #(
  parameter int DATA_WIDTH  = 16,
  parameter int DATA_LENGTH = 8,
  parameter int PAD_MAX     = 1,
  localparam int CW = ($clog2(DATA_LENGTH + 1) > 1) ? $clog2(DATA_LENGTH + 1) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_last,
  output logic [DATA_WIDTH*DATA_LENGTH-1:0] out_vec,
  output logic [CW-1:0]                     out_count,
  output logic                              out_valid,
  input  logic                              out_ready
);

  localparam int IW = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_LENGTH - 1);
  localparam logic [DATA_WIDTH-1:0] PAD = (PAD_MAX != 0) ? {DATA_WIDTH{1'b1}} : '0;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [IW-1:0]   idx_reg;
  logic [CW-1:0]   count_reg;
  logic            accept;
  logic            row_done;
  logic            release_vec;

  // Handshake outputs come straight from the state register: no input-to-output paths.
  assign in_ready    = (state_reg == FILL);
  assign out_valid   = (state_reg == HOLD);
  assign out_count   = count_reg;
  assign accept      = in_valid && in_ready;
  assign row_done    = accept && ((idx_reg == IDX_LAST) || in_last);
  assign release_vec = (state_reg == HOLD) && out_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FILL:    if (row_done) state_next = HOLD;
      HOLD:    if (out_ready) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FILL;
      idx_reg   <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (row_done) begin
        count_reg <= CW'(idx_reg) + CW'(1);
      end else if (accept) begin
        idx_reg <= idx_reg + IW'(1);
      end
      if (release_vec) begin
        idx_reg   <= '0;
        count_reg <= '0;
      end
    end
  end

  // Each slot owns its register; releasing a vector re-pads every slot so a
  // following short row never exposes stale data.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_LENGTH; gi++) begin : g_slot
      logic [DATA_WIDTH-1:0] slot_reg;

      always_ff @(posedge clk) begin
        if (rst || release_vec) begin
          slot_reg <= PAD;
        end else if (accept && (idx_reg == IW'(gi))) begin
          slot_reg <= in_data;
        end
      end

      assign out_vec[gi*DATA_WIDTH +: DATA_WIDTH] = slot_reg;
    end
  endgenerate

endmodule

// File: tb/tb_vec_packer.sv
// Self-checking bench for vec_packer: table-driven rows scored through queues,
// plus backpressure, mid-row reset and DATA_LENGTH=1 sequences.
module tb_vec_packer;

  typedef struct {
    int          n;
    logic [15:0] d [8];
    bit          use_last;
    int          gap;
  } row_t;

  typedef struct packed {
    logic [127:0] vec;
    logic [3:0]   cnt;
    logic [15:0]  mn;
    logic [15:0]  mx;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b1;

  logic         rdy1, v1, rdy0, v0;
  logic [127:0] vec1, vec0;
  logic [3:0]   cnt1, cnt0;

  logic [15:0]  d1_data = '0;
  logic         d1_valid = 1'b0;
  logic         d1_ready, d1_ovalid;
  logic [15:0]  d1_vec;
  logic [0:0]   d1_count;

  int checks = 0;
  int errors = 0;
  int d1_accepts = 0;
  bit d1_mon_en = 1'b0;

  exp_t        q1[$];
  exp_t        q0[$];
  logic [15:0] qd[$];
  row_t        rows[5];

  always #5 clk = ~clk;

  vec_packer #(.DATA_WIDTH(16), .DATA_LENGTH(8), .PAD_MAX(1)) u_pad1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
    .in_last(in_last), .out_vec(vec1), .out_count(cnt1), .out_valid(v1), .out_ready(out_ready)
  );

  vec_packer #(.DATA_WIDTH(16), .DATA_LENGTH(8), .PAD_MAX(0)) u_pad0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
    .in_last(in_last), .out_vec(vec0), .out_count(cnt0), .out_valid(v0), .out_ready(out_ready)
  );

  vec_packer #(.DATA_WIDTH(16), .DATA_LENGTH(1), .PAD_MAX(1)) u_len1 (
    .clk(clk), .rst(rst), .in_data(d1_data), .in_valid(d1_valid), .in_ready(d1_ready),
    .in_last(1'b0), .out_vec(d1_vec), .out_count(d1_count), .out_valid(d1_ovalid), .out_ready(1'b1)
  );

  function automatic exp_t build(row_t r, bit padmax);
    exp_t e;
    e.vec = '0;
    e.cnt = 4'(r.n);
    e.mn  = 16'hFFFF;
    e.mx  = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      if (i < r.n) begin
        e.vec[i*16 +: 16] = r.d[i];
        if (r.d[i] < e.mn) e.mn = r.d[i];
        if (r.d[i] > e.mx) e.mx = r.d[i];
      end else begin
        e.vec[i*16 +: 16] = padmax ? 16'hFFFF : 16'h0000;
      end
    end
    return e;
  endfunction

  task automatic check(string name, logic [127:0] got, logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  // Pad-max instance: compare each released vector and the tree's min result.
  always @(negedge clk) begin
    if (!rst && v1 && out_ready) begin
      logic [15:0] m;
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL pad1_unexpected_vec: got %h expected none", vec1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        m = 16'hFFFF;
        for (int i = 0; i < 8; i++) if (vec1[i*16 +: 16] < m) m = vec1[i*16 +: 16];
        check("pad1_vec", vec1, e.vec);
        check("pad1_count", 128'(cnt1), 128'(e.cnt));
        check("pad1_min", 128'(m), 128'(e.mn));
      end
    end
  end

  // Pad-zero instance: same rows, zero pads, max result.
  always @(negedge clk) begin
    if (!rst && v0 && out_ready) begin
      logic [15:0] m;
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL pad0_unexpected_vec: got %h expected none", vec0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        m = 16'h0000;
        for (int i = 0; i < 8; i++) if (vec0[i*16 +: 16] > m) m = vec0[i*16 +: 16];
        check("pad0_vec", vec0, e.vec);
        check("pad0_count", 128'(cnt0), 128'(e.cnt));
        check("pad0_max", 128'(m), 128'(e.mx));
      end
    end
  end

  // DATA_LENGTH=1 instance: pop the previous accept first, then record this one.
  always @(negedge clk) begin
    if (!rst && d1_mon_en) begin
      if (d1_ovalid) begin
        if (qd.size() == 0) begin
          checks++; errors++;
          $display("FAIL len1_unexpected_vec: got %h expected none", d1_vec);
        end else begin
          logic [15:0] e;
          e = qd.pop_front();
          check("len1_vec", 128'(d1_vec), 128'(e));
          check("len1_count", 128'(d1_count), 128'(1));
        end
      end
      if (d1_valid && d1_ready) begin
        qd.push_back(d1_data);
        d1_accepts++;
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!rdy1) begin
      @(posedge clk); #1;
      t++;
      if (t > 50) begin
        checks++; errors++;
        $display("FAIL in_ready_timeout: got 0 expected 1 within 50 cycles");
        break;
      end
    end
  endtask

  task automatic send_row(row_t r);
    for (int i = 0; i < r.n; i++) begin
      in_data  = r.d[i];
      in_valid = 1'b1;
      in_last  = r.use_last && (i == r.n - 1);
      wait_ready();
      @(posedge clk); #1;
      if (r.gap > 0 && i < r.n - 1) begin
        in_valid = 1'b0;
        in_last  = 1'b1;          // must be ignored without a handshake
        repeat (r.gap) begin @(posedge clk); #1; end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    q1.push_back(build(r, 1'b1));
    q0.push_back(build(r, 1'b0));
    check("latency_out_valid", 128'(v1), 128'(1));
  endtask

  task automatic check_idle(string tag);
    check({tag, "_valid"}, 128'(v1), 128'(0));
    check({tag, "_count"}, 128'(cnt1), 128'(0));
    check({tag, "_in_ready"}, 128'(rdy1), 128'(1));
    check({tag, "_pad1_vec"}, vec1, {128{1'b1}});
    check({tag, "_pad0_vec"}, vec0, 128'(0));
  endtask

  initial begin
    exp_t held;

    rows[0].n = 8; rows[0].use_last = 1'b0; rows[0].gap = 0;
    rows[0].d = '{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    rows[1].n = 3; rows[1].use_last = 1'b1; rows[1].gap = 0;
    rows[1].d = '{16'h0030, 16'h0010, 16'h0020, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    rows[2].n = 1; rows[2].use_last = 1'b1; rows[2].gap = 0;
    rows[2].d = '{16'h1234, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    rows[3].n = 8; rows[3].use_last = 1'b1; rows[3].gap = 0;
    rows[3].d = '{16'hA001, 16'h5A5A, 16'hFFFE, 16'h0007, 16'h8000, 16'h1111, 16'hC3C3, 16'h0100};
    rows[4].n = 5; rows[4].use_last = 1'b1; rows[4].gap = 2;
    rows[4].d = '{16'h0400, 16'h0300, 16'hF00F, 16'h0002, 16'h7FFF, 16'h0, 16'h0, 16'h0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_idle("reset");
    check("reset_len1_ready", 128'(d1_ready), 128'(1));
    check("reset_len1_valid", 128'(d1_ovalid), 128'(0));

    // Table of rows, consumer always ready.
    out_ready = 1'b1;
    for (int r = 0; r < 5; r++) send_row(rows[r]);
    repeat (2) @(posedge clk); #1;

    // Backpressure: vector held while new data is offered.
    out_ready = 1'b0;
    send_row(rows[1]);
    held = build(rows[1], 1'b1);
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_in_ready", 128'(rdy1), 128'(0));
      check("bp_vec_stable", vec1, held.vec);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 128'(rdy1), 128'(1));
    check("bp_release_valid", 128'(v1), 128'(0));
    send_row(rows[3]);
    repeat (2) @(posedge clk); #1;

    // Reset mid-row, with a handshake offered in the reset cycle.
    for (int i = 0; i < 4; i++) begin
      in_data = rows[0].d[i]; in_valid = 1'b1;
      wait_ready();
      @(posedge clk); #1;
    end
    rst = 1'b1; in_data = 16'h7777; in_valid = 1'b1; in_last = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check_idle("midrst");
    send_row(rows[0]);
    repeat (2) @(posedge clk); #1;

    // DATA_LENGTH=1: one vector every two cycles with the consumer tied ready.
    d1_mon_en = 1'b1;
    d1_valid  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      d1_data = 16'(16'h0100 + c * 3);
      @(posedge clk); #1;
    end
    d1_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("len1_accepts", 128'(d1_accepts), 128'(10));
    check("len1_queue_drained", 128'(qd.size()), 128'(0));
    check("pad1_queue_drained", 128'(q1.size()), 128'(0));
    check("pad0_queue_drained", 128'(q0.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vec_packer.md
Name: vec_packer

Overview:
- Serial-to-parallel stage that sits directly upstream of the combinational min-reduction tree in the attention datapath.
- Accepts one DATA_WIDTH element per handshake and packs up to DATA_LENGTH elements into the packed vector bus the reduction tree consumes. Element 0 goes in the LSB slot.
- Short rows, terminated early by in_last, get their unused slots filled with a neutral pad value, so a downstream min (or max) result is unaffected.
- Holds the packed vector stable until the consumer accepts it.

Parameters:
- DATA_WIDTH, 16, bits per element (unsigned).
- DATA_LENGTH, 8, elements per packed vector; must be >= 1.
- PAD_MAX, 1, pad value select: 1 = all ones (neutral for min), 0 = all zeros (neutral for max).

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  DATA_WIDTH  element to pack.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  packer can accept an element this cycle.
- in_last  input  1  qualifies the current element as the final one of its row.
- out_vec  output  DATA_WIDTH*DATA_LENGTH  packed vector; slot i = out_vec[i*DATA_WIDTH +: DATA_WIDTH].
- out_count  output  CW  number of real (non-pad) elements in out_vec; CW = $clog2(DATA_LENGTH+1), minimum 1.
- out_valid  output  1  out_vec and out_count are valid.
- out_ready  input  1  consumer accepts out_vec this cycle.

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset state:
  - state = FILL, idx = 0.
  - Every out_vec slot = PAD.
  - out_count = 0, out_valid = 0, in_ready = 1 in the cycle after rst is sampled high.
  - A partially filled row is discarded on reset; there is no residue.
- PAD = {DATA_WIDTH{1'b1}} if PAD_MAX = 1, otherwise all zeros.
- State FILL:
  - in_ready = 1, out_valid = 0.
  - On in_valid && in_ready: slot[idx] <= in_data.
  - If idx == DATA_LENGTH-1 or in_last: go to HOLD and set out_count <= idx+1.
  - Otherwise: idx <= idx+1.
- State HOLD:
  - in_ready = 0, out_valid = 1.
  - out_vec and out_count are stable and ignore in_valid/in_data.
  - On out_ready: go to FILL, idx <= 0, all slots <= PAD, out_count <= 0.
- in_ready and out_valid are decoded from registered state only; there is no combinational path from in_valid or out_ready.
- Latency: the element accepted at cycle N that completes a row gives out_valid = 1 at cycle N+1.
- Throughput: a full row takes DATA_LENGTH accept cycles, plus at least 1 HOLD cycle, plus the return to FILL. The best case is one vector per DATA_LENGTH+1 cycles.
- Boundary conditions:
  - in_last on the first element: out_count = 1; slots 1..DATA_LENGTH-1 = PAD.
  - in_last on element DATA_LENGTH-1: identical to natural completion.
  - in_last is ignored unless in_valid && in_ready.
  - DATA_LENGTH = 1: every accepted element completes a row.
  - In HOLD, in_valid is held off by in_ready = 0; there is no data loss and no overwrite.
  - out_ready while out_valid = 0 has no effect.
  - rst has priority over every handshake in the same cycle.
- The idx counter is $clog2(DATA_LENGTH) bits wide, minimum 1, and never exceeds DATA_LENGTH-1.
- No arithmetic on data: elements are copied bit-exact.

Test Plan:
- Full row: DW=16, DL=8, feed 8,7,6,5,4,3,2,1 back-to-back with out_ready=1 -> out_valid at the cycle after the 8th accept; out_vec slot0=8 … slot7=1; out_count=8; the downstream tree gives min=1.
- Short row: feed 0x0030, 0x0010, 0x0020 with in_last on the 3rd, PAD_MAX=1 -> slots 3..7 = 0xFFFF; out_count=3; min=0x0010. With PAD_MAX=0 -> slots 3..7 = 0x0000.
- Backpressure: complete a row with out_ready=0 for 5 cycles while in_valid=1 with new data -> in_ready=0 throughout; out_vec unchanged. Then out_ready=1 for 1 cycle -> next cycle in_ready=1, and the next row starts at slot 0.
- Single-element row: in_last on the first element 0x1234 -> out_count=1; slot0=0x1234; all other slots PAD.
- Reset mid-row: accept 4 elements, assert rst for 1 cycle -> out_valid=0, out_count=0, all slots PAD. Feeding a new 8-element row then produces only the new data.
- DATA_LENGTH=1 instance: each accept -> HOLD; out_count=1; back-to-back rows at 1 vector per 2 cycles with out_ready tied high.
